// File: rtl/aes_pkg.sv
// AES constants, controller FSM encoding and byte-level round helpers shared by the
// iterative encrypt sequencer and its combinational round datapath.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_AES128   = 10;
  localparam int NR_AES192   = 12;
  localparam int NR_AES256   = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_fsm_e;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Forward S-box, entry b at bits [2047-8*b -: 8] (row-major, 16 entries per row).
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  // Byte i of a block sits at [127-8*i -: 8] with i = row + 4*col; row r rotates left by r.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: subBytes, shiftRows, mixColumns (skipped on
// the final round) and addRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last,
  output logic [AES_BLOCK_W-1:0] next_state
);

  aes_block_t sub_out;
  aes_block_t shift_out;
  aes_block_t mix_out;

  always_comb begin
    sub_out = '0;
    for (int i = 0; i < 16; i++) begin
      sub_out[127-8*i -: 8] = sub_byte(state[127-8*i -: 8]);
    end
  end

  assign shift_out = shift_rows(sub_out);

  always_comb begin
    mix_out = shift_out;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        mix_out[127-32*c -: 32] = mix_column(shift_out[127-32*c -: 32]);
      end
    end
  end

  assign next_state = mix_out ^ round_key;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES encrypt sequencer: one round per cycle, round keys fetched by index.
// Optional AES_ENC_CTRL_ABORT_EN adds an abort input that drops the block in flight.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR       = NR_AES128,
  parameter int RK_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AES_BLOCK_W-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [AES_BLOCK_W-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RK_IDX_W-1:0]    rk_idx,
  input  logic [AES_BLOCK_W-1:0] round_key,
  output logic                   busy
`ifdef AES_ENC_CTRL_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("aes_enc_ctrl: NR must be 10, 12 or 14");
  end

  if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_enc_ctrl: RK_IDX_W too narrow to index NR round keys");
  end

  localparam logic [RK_IDX_W-1:0] LAST_ROUND = RK_IDX_W'(NR);

  aes_fsm_e            fsm_q;
  aes_fsm_e            fsm_d;
  logic [RK_IDX_W-1:0] round_q;
  aes_block_t          state_reg;
  aes_block_t          out_q;
  aes_block_t          round_out;
  logic                accept;
  logic                last_round;
  logic                abort_hit;

  assign accept     = in_valid && in_ready;
  assign last_round = (round_q == LAST_ROUND);

`ifdef AES_ENC_CTRL_ABORT_EN
  assign abort_hit = abort && (fsm_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  aes_enc_round u_round (
    .state      (state_reg),
    .round_key  (round_key),
    .last       (last_round),
    .next_state (round_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (accept)     fsm_d = ROUND;
      ROUND:   if (last_round) fsm_d = DONE;
      DONE:    if (out_ready)  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (abort_hit) begin
      fsm_d = IDLE;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    unique case (fsm_q)
      IDLE:  in_ready = !rst;
      ROUND: begin
        busy   = 1'b1;
        rk_idx = round_q;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Ciphertext is captured on the final round so it survives the next block's rounds.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q   <= '0;
      state_reg <= '0;
      out_q     <= '0;
    end else if (abort_hit) begin
      round_q   <= '0;
      state_reg <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_reg <= in ^ round_key;
            round_q   <= RK_IDX_W'(1);
          end
        end
        ROUND: begin
          state_reg <= round_out;
          if (last_round) begin
            out_q   <= round_out;
            round_q <= '0;
          end else begin
            round_q <= round_q + RK_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Self-checking bench for aes_enc_ctrl against a byte-array AES model with its own
// derived S-box and key expansion.
module tb_aes_enc_ctrl;

  localparam int NR = 10;

  logic         clk;
  logic         rst;
  logic [127:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dout;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         busy;

  logic [127:0] rk [0:15];
  logic [7:0]   sb [0:255];
  int           rk_seen[$];
  int           rk_pre;
  int           checks;
  int           errors;

  assign round_key = rk[rk_idx];

`ifdef AES_ENC_CTRL_ABORT_EN
  logic         abort;
  logic [127:0] din14;
  logic [127:0] dout14;
  logic         iv14;
  logic         ir14;
  logic         ov14;
  logic         or14;
  logic [3:0]   rk_idx14;
  logic [127:0] rkey14;
  logic         busy14;
  logic         abort14;

  assign rkey14 = rk[rk_idx14];
`endif

  aes_enc_ctrl #(.NR(NR), .RK_IDX_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .busy      (busy)
`ifdef AES_ENC_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

`ifdef AES_ENC_CTRL_ABORT_EN
  aes_enc_ctrl #(.NR(14), .RK_IDX_W(4)) u_dut14 (
    .clk       (clk),
    .rst       (rst),
    .in        (din14),
    .in_valid  (iv14),
    .in_ready  (ir14),
    .out       (dout14),
    .out_valid (ov14),
    .out_ready (or14),
    .rk_idx    (rk_idx14),
    .round_key (rkey14),
    .busy      (busy14),
    .abort     (abort14)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key left-aligned in 256 bits; nk = key length in 32-bit words.
  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:63];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k <= nr; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rd][127-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic encrypt(input logic [127:0] pt, output int lat);
    @(negedge clk);
    rk_pre   = int'(rk_idx);
    din      = pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    din      = rand128();
    rk_seen.delete();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      rk_seen.push_back(int'(rk_idx));
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d want 0", rk_idx); end
    checks++; if (dout !== 128'h0) begin errors++; $display("FAIL reset_out got %h want 0", dout); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_fips_b();
    int   lat;
    logic seq_ok;
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, NR);
    encrypt(128'h3243f6a8885a308d313198a2e0370734, lat);
    checks++; if (lat != NR + 1) begin errors++; $display("FAIL fipsb_latency got %0d want %0d", lat, NR + 1); end
    seq_ok = (rk_pre == 0) && (rk_seen.size() == NR);
    foreach (rk_seen[i]) if (rk_seen[i] != i + 1) seq_ok = 1'b0;
    checks++; if (seq_ok !== 1'b1) begin errors++; $display("FAIL fipsb_rk_seq got pre=%0d n=%0d want 0 then 1..%0d", rk_pre, rk_seen.size(), NR); end
    checks++; if (dout !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL fipsb_out got %h want 3925841d02dc09fbdc118597196a0b32", dout); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL fipsb_done_rk_idx got %0d want 0", rk_idx); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fipsb_after_hs got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (dout !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL fipsb_out_kept got %h want 3925841d02dc09fbdc118597196a0b32", dout); end
  endtask

  task automatic test_fips_c1();
    int lat;
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR);
    encrypt(128'h00112233445566778899aabbccddeeff, lat);
    checks++; if (dout !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a || out_valid !== 1'b1) begin errors++; $display("FAIL fipsc1_out got %h valid=%b want 69c4e0d86a7b0430d8cdb78070b4c55a", dout, out_valid); end
    handshake();
  endtask

  task automatic test_random();
    int           lat;
    logic [127:0] pt, exp_ct;
    for (int n = 0; n < 6; n++) begin
      expand_key({rand128(), 128'h0}, 4, NR);
      pt     = rand128();
      exp_ct = aes_model(pt, NR);
      encrypt(pt, lat);
      checks++; if (dout !== exp_ct || lat != NR + 1) begin errors++; $display("FAIL random_%0d got %h lat=%0d want %h lat=%0d", n, dout, lat, exp_ct, NR + 1); end
      handshake();
    end
  endtask

  task automatic test_back_pressure();
    int           lat;
    logic [127:0] pt, exp_ct;
    pt     = rand128();
    exp_ct = aes_model(pt, NR);
    encrypt(pt, lat);
    for (int i = 0; i < 20; i++) begin
      din      = rand128();
      in_valid = 1'b1;
      #1;
      checks++; if (dout !== exp_ct || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got %h v=%b r=%b want %h v=1 r=0", i, dout, out_valid, in_ready, exp_ct); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_early_ready();
    int           lat;
    logic [127:0] pt, exp_ct;
    pt        = rand128();
    exp_ct    = aes_model(pt, NR);
    out_ready = 1'b1;
    encrypt(pt, lat);
    checks++; if (dout !== exp_ct || lat != NR + 1) begin errors++; $display("FAIL early_out got %h lat=%0d want %h lat=%0d", dout, lat, exp_ct, NR + 1); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL early_hs got v=%b busy=%b want 0/0", out_valid, busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_busy_reject();
    int           lat;
    int           n;
    logic [127:0] pa, pb, ea, eb;
    pa = rand128();
    pb = rand128();
    ea = aes_model(pa, NR);
    eb = aes_model(pb, NR);
    @(negedge clk);
    din = pa;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    din = pb;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    din = rand128();
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (dout !== ea || out_valid !== 1'b1) begin errors++; $display("FAIL busy_first got %h v=%b want %h", dout, out_valid, ea); end
    handshake();
    encrypt(pb, lat);
    checks++; if (dout !== eb) begin errors++; $display("FAIL busy_second got %h want %h", dout, eb); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int           lat;
    int           n;
    logic         seen;
    logic [127:0] pt, exp_ct;
    @(negedge clk);
    din = rand128();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 40) begin @(negedge clk); n++; end
    checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL rstmid_reach got %0d want 5", rk_idx); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0) begin errors++; $display("FAIL rstmid_state got v=%b busy=%b rk=%0d want 0/0/0", out_valid, busy, rk_idx); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse got %b want 0", seen); end
    pt     = rand128();
    exp_ct = aes_model(pt, NR);
    encrypt(pt, lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstdone_state got v=%b busy=%b want 0/0", out_valid, busy); end
    encrypt(pt, lat);
    checks++; if (dout !== exp_ct) begin errors++; $display("FAIL rstmid_next got %h want %h", dout, exp_ct); end
    handshake();
  endtask

`ifdef AES_ENC_CTRL_ABORT_EN
  task automatic test_abort();
    int           lat;
    int           n;
    logic         seen;
    logic [127:0] pt, exp_ct;
    expand_key({rand128(), 128'h0}, 4, NR);
    pt     = rand128();
    exp_ct = aes_model(pt, NR);
    encrypt(pt, lat);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_done got v=%b busy=%b r=%b want 0/0/1", out_valid, busy, in_ready); end
    @(negedge clk);
    din = pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_round got pulse=%b busy=%b want 0/0", seen, busy); end
    din = pt;
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_accept got busy=%b want 1", busy); end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (dout !== exp_ct) begin errors++; $display("FAIL abort_idle_out got %h want %h", dout, exp_ct); end
    handshake();
  endtask

  task automatic test_aes256();
    int           lat;
    logic [127:0] pt;
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    pt = 128'h00112233445566778899aabbccddeeff;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      din14 = pt;
      iv14  = 1'b1;
      @(negedge clk);
      iv14 = 1'b0;
      lat  = 1;
      while (ov14 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      if (k == 0) begin
        checks++; if (dout14 !== 128'h8ea2b7ca516745bfeafc49904b496089 || lat != 15) begin errors++; $display("FAIL aes256_c3 got %h lat=%0d want 8ea2b7ca516745bfeafc49904b496089 lat=15", dout14, lat); end
      end else begin
        checks++; if (dout14 !== aes_model(pt, 14)) begin errors++; $display("FAIL aes256_random got %h want %h", dout14, aes_model(pt, 14)); end
      end
      or14 = 1'b1;
      @(negedge clk);
      or14 = 1'b0;
      expand_key({rand128(), rand128()}, 8, 14);
      pt = rand128();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    din       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) rk[i] = '0;
`ifdef AES_ENC_CTRL_ABORT_EN
    abort   = 1'b0;
    abort14 = 1'b0;
    din14   = '0;
    iv14    = 1'b0;
    or14    = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_random();
    test_back_pressure();
    test_early_ready();
    test_busy_reject();
    test_reset_mid();
`ifdef AES_ENC_CTRL_ABORT_EN
    test_abort();
    test_aes256();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_ctrl.md
Name: aes_enc_ctrl

Overview:
Iterative AES encryption sequencer. It accepts one 128-bit plaintext block over a valid/ready handshake and holds the running state in a register. It runs one round per cycle through a combinational round datapath (subBytes, shiftRows, mixColumns, addRoundKey), fetching round keys by index from the key-schedule store. It presents the ciphertext on a held valid/ready output. It sits between the host block interface and the encrypt datapath.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256); other values are an elaboration error.
RK_IDX_W, 4, width of the round-key index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in  input  128  plaintext block; byte 0 at [127:120], column-major state order.
in_valid  input  1  plaintext valid.
in_ready  output  1  block can accept plaintext.
out  output  128  ciphertext, same byte order as in.
out_valid  output  1  ciphertext valid.
out_ready  input  1  consumer accepts ciphertext.
rk_idx  output  RK_IDX_W  round-key index requested this cycle.
round_key  input  128  round key for rk_idx, returned combinationally in the same cycle.
busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset (rst high at an edge):
  - FSM goes to IDLE; round counter goes to 0.
  - out = 0, out_valid = 0, busy = 0, rk_idx = 0.
  - in_ready is forced to 0 while rst is high.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1, rk_idx = 0.
  - On in_valid && in_ready at edge T: state_reg <= in ^ round_key (key 0), round counter <= 1, go to ROUND.
- ROUND:
  - rk_idx = round counter r (1..NR).
  - Each edge: state_reg <= aes_enc_round(state_reg, round_key, last = (r == NR)); r increments.
  - mixColumns is bypassed only when r == NR.
  - After the edge where r == NR, go to DONE.
  - in_ready = 0.
- DONE:
  - out = state_reg, out_valid = 1, rk_idx = 0.
  - out and out_valid stay stable until out_ready is high.
  - On out_valid && out_ready: go to IDLE; out_valid = 0 next cycle.
  - out keeps its last value after the handshake (not cleared).
- Latency:
  - Input accepted at edge T; out_valid is high from cycle T+NR+1.
  - Throughput is one block per NR+2 cycles minimum (one IDLE cycle between blocks).
  - No overlap: in_ready = 0 in DONE even if out_ready is high.
- Boundary conditions:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - out_ready held high from before DONE: handshake completes in the first DONE cycle.
  - rst asserted mid-ROUND or in DONE: the block is discarded, reset values apply next cycle, no out_valid pulse.
  - in or in_valid changing while not ready has no effect.
- Arithmetic: all key additions are 128-bit XOR. The round counter is RK_IDX_W bits wide and never exceeds NR.

Optional Feature:
Macro AES_ENC_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high at an edge in ROUND or DONE: FSM goes to IDLE, round counter to 0, out_valid = 0 next cycle.
  - state_reg is cleared to 0 (no partial-state leakage).
  - abort in IDLE is ignored and has priority over no handshake in that cycle.
  - rst has priority over abort.
- Not defined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package aes_pkg:
  - AES_BLOCK_W = 128.
  - NR_AES128/192/256 = 10/12/14.
  - FSM state enum {IDLE, ROUND, DONE}.
- One natural combinational sub-module, aes_enc_round:
  - Ports: state in, round key, last flag, next state out.
  - Order: subBytes → shiftRows (the team's existing shiftRows block) → mixColumns (bypassed when last) → addRoundKey.
- The controller holds the FSM, round counter and state register only.

Test Plan:
- FIPS-197 App. B:
  - Bench supplies round keys expanded from key 2b7e151628aed2a6abf7158809cf4f3c.
  - Stimulus: in = 3243f6a8885a308d313198a2e0370734.
  - Expected: out = 3925841d02dc09fbdc118597196a0b32; out_valid rises exactly 11 cycles after the accept edge; rk_idx sequence is 0,1..10.
- FIPS-197 App. C.1:
  - Key 000102030405060708090a0b0c0d0e0f.
  - Stimulus: in = 00112233445566778899aabbccddeeff.
  - Expected: out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure:
  - out_ready held low for 20 cycles in DONE → out and out_valid stable throughout, in_ready = 0.
  - Raise out_ready → IDLE next cycle, in_ready = 1.
- Busy rejection:
  - in_valid pulsed with a different block during ROUND → ignored; first block's ciphertext unchanged.
  - Second block accepted only in IDLE; both ciphertexts correct.
- Reset mid-operation:
  - rst high at round 5 → next cycle out_valid = 0, busy = 0, rk_idx = 0, in_ready = 1 after rst drops.
  - Next block encrypts correctly.
- With AES_ENC_CTRL_ABORT_EN:
  - abort in DONE → out_valid = 0 next cycle, no handshake, FSM in IDLE.
  - NR=14 run with App. C.3 vector gives 8ea2b7ca516745bfeafc49904b496089.
